// File: rtl/memp_writeback_packer.sv
// Packs solver results lane by lane into cluster-wide memP words and writes them at consecutive addresses.
// Optional early-termination port enabled by defining MEMP_WB_FLUSH_EN.
module memp_writeback_packer #(
  parameter int number_of_clusters              = 1,
  parameter int number_of_equations_per_cluster = 9,
  parameter int element_width                   = 32,
  parameter int address_width                   = 20
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic                                                     start,
  input  logic [address_width-1:0]                                 base_address,
  input  logic                                                     elem_valid,
  input  logic [element_width-1:0]                                 elem_data,
`ifdef MEMP_WB_FLUSH_EN
  input  logic                                                     flush,
`endif
  output logic                                                     elem_ready,
  output logic                                                     write_enable,
  output logic [number_of_equations_per_cluster*element_width-1:0] input_data,
  output logic [address_width-1:0]                                 input_write_address,
  output logic                                                     busy,
  output logic                                                     finish
);

  localparam int N      = number_of_equations_per_cluster;
  localparam int W      = element_width;
  localparam int WORD_W = N * W;
  localparam int LW     = $clog2(N + 1);
  localparam int CW     = (number_of_clusters > 1) ? $clog2(number_of_clusters) : 1;

  localparam logic [LW-1:0] LAST_LANE    = LW'(N - 1);
  localparam logic [CW-1:0] LAST_CLUSTER = CW'(number_of_clusters - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  logic [LW-1:0]   lane_cnt;
  logic [CW-1:0]   cluster_cnt;
  logic            flushed;

  logic            accept;
  logic            flush_req;
  logic [LW-1:0]   fill_cnt;
  logic [WORD_W-1:0] word_next;

  assign accept = elem_valid && elem_ready;

`ifdef MEMP_WB_FLUSH_EN
  assign flush_req = flush && (state == FILL);
`else
  assign flush_req = 1'b0;
`endif

  // Lanes occupied once this cycle's element (if any) has landed.
  assign fill_cnt = accept ? (lane_cnt + 1'b1) : lane_cnt;

  always_comb begin
    word_next = input_data;
    for (int i = 0; i < N; i++) begin
      if (accept && (lane_cnt == LW'(i))) begin
        word_next[i*W +: W] = elem_data;
      end
      // Earlier clusters leave stale lanes behind, so a flushed word is padded explicitly.
      if (flush_req && (LW'(i) >= fill_cnt)) begin
        word_next[i*W +: W] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      lane_cnt            <= '0;
      cluster_cnt         <= '0;
      flushed             <= 1'b0;
      input_data          <= '0;
      input_write_address <= '0;
      write_enable        <= 1'b0;
      elem_ready          <= 1'b0;
      busy                <= 1'b0;
      finish              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            input_write_address <= base_address;
            lane_cnt            <= '0;
            cluster_cnt         <= '0;
            flushed             <= 1'b0;
            input_data          <= '0;
            elem_ready          <= 1'b1;
            busy                <= 1'b1;
            state               <= FILL;
          end
        end

        FILL: begin
          if (flush_req) begin
            input_data <= word_next;
            lane_cnt   <= fill_cnt;
            elem_ready <= 1'b0;
            if (fill_cnt == '0) begin
              finish <= 1'b1;
              state  <= DONE;
            end else begin
              flushed      <= 1'b1;
              write_enable <= 1'b1;
              state        <= WRITE;
            end
          end else if (accept) begin
            input_data <= word_next;
            lane_cnt   <= lane_cnt + 1'b1;
            if (lane_cnt == LAST_LANE) begin
              elem_ready   <= 1'b0;
              write_enable <= 1'b1;
              state        <= WRITE;
            end
          end
        end

        WRITE: begin
          write_enable <= 1'b0;
          if (flushed || (cluster_cnt == LAST_CLUSTER)) begin
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            cluster_cnt         <= cluster_cnt + 1'b1;
            input_write_address <= input_write_address + 1'b1;
            lane_cnt            <= '0;
            elem_ready          <= 1'b1;
            state               <= FILL;
          end
        end

        DONE: begin
          finish <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state        <= IDLE;
          write_enable <= 1'b0;
          elem_ready   <= 1'b0;
          busy         <= 1'b0;
          finish       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memp_writeback_packer.sv
// Directed bench for memp_writeback_packer: three instances (1, 3 and 2 clusters) share the element stream.
// Flush scenarios are exercised only when MEMP_WB_FLUSH_EN is defined.
module tb_memp_writeback_packer;

  localparam int N  = 9;
  localparam int W  = 32;
  localparam int AW = 20;
  localparam int WW = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start [3];
  logic [AW-1:0] base_address;
  logic          elem_valid;
  logic [W-1:0]  elem_data;
`ifdef MEMP_WB_FLUSH_EN
  logic          flush;
`endif

  logic          rdy  [3];
  logic          we   [3];
  logic          busy [3];
  logic          fin  [3];
  logic [WW-1:0] data [3];
  logic [AW-1:0] addr [3];

  memp_writeback_packer #(.number_of_clusters(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .base_address(base_address),
    .elem_valid(elem_valid), .elem_data(elem_data),
`ifdef MEMP_WB_FLUSH_EN
    .flush(flush),
`endif
    .elem_ready(rdy[0]), .write_enable(we[0]), .input_data(data[0]),
    .input_write_address(addr[0]), .busy(busy[0]), .finish(fin[0])
  );

  memp_writeback_packer #(.number_of_clusters(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .base_address(base_address),
    .elem_valid(elem_valid), .elem_data(elem_data),
`ifdef MEMP_WB_FLUSH_EN
    .flush(flush),
`endif
    .elem_ready(rdy[1]), .write_enable(we[1]), .input_data(data[1]),
    .input_write_address(addr[1]), .busy(busy[1]), .finish(fin[1])
  );

  memp_writeback_packer #(.number_of_clusters(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .base_address(base_address),
    .elem_valid(elem_valid), .elem_data(elem_data),
`ifdef MEMP_WB_FLUSH_EN
    .flush(flush),
`endif
    .elem_ready(rdy[2]), .write_enable(we[2]), .input_data(data[2]),
    .input_write_address(addr[2]), .busy(busy[2]), .finish(fin[2])
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/finish recorder, one record set per instance.
  logic [AW-1:0] wr_addr [3][16];
  logic [WW-1:0] wr_data [3][16];
  int            wr_cyc  [3][16];
  int            wr_n    [3];
  int            fin_n   [3];
  int            fin_cyc [3];
  int            rdy_wr  [3];

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (we[s] === 1'b1) begin
        if (wr_n[s] < 16) begin
          wr_addr[s][wr_n[s]] <= addr[s];
          wr_data[s][wr_n[s]] <= data[s];
          wr_cyc[s][wr_n[s]]  <= cyc;
        end
        wr_n[s] <= wr_n[s] + 1;
        if (rdy[s] !== 1'b0) rdy_wr[s] <= rdy_wr[s] + 1;
      end
      if (fin[s] === 1'b1) begin
        fin_n[s]   <= fin_n[s] + 1;
        fin_cyc[s] <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack(input int first, input int nval);
    logic [WW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      if (j < nval) r[j*W +: W] = W'(first + j);
    end
    return r;
  endfunction

  task automatic start_pass(input int sel, input logic [AW-1:0] b);
    @(negedge clk);
    base_address = b;
    start[sel]   = 1'b1;
    @(negedge clk);
    start[sel]   = 1'b0;
  endtask

  // Offers n elements first..first+n-1; returns #1 after the edge that accepted the last one.
  task automatic send(input int sel, input int n, input int first, input bit gaps);
    int  k = 0;
    int  budget = 0;
    bit  acc;
    while (k < n && budget < 400) begin
      @(negedge clk);
      elem_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      elem_data  = W'(first + k);
      acc        = elem_valid && rdy[sel];
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        last_acc = cyc;
      end
      budget++;
    end
    elem_valid = 1'b0;
    if (k != n) chk("send_timeout", WW'(k), WW'(n));
  endtask

  task automatic wait_idle(input int sel);
    int t = 0;
    while (busy[sel] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    #1;
    chk("idle_reached", WW'(busy[sel]), '0);
  endtask

  int s_w;
  int s_f;

  initial begin
    rst_n        = 1'b1;
    start[0]     = 1'b0;
    start[1]     = 1'b0;
    start[2]     = 1'b0;
    base_address = '0;
    elem_valid   = 1'b0;
    elem_data    = '0;
`ifdef MEMP_WB_FLUSH_EN
    flush        = 1'b0;
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_we",     WW'(we[0]),   '0);
    chk("rst_ready",  WW'(rdy[0]),  '0);
    chk("rst_busy",   WW'(busy[0]), '0);
    chk("rst_finish", WW'(fin[0]),  '0);
    chk("rst_data",   data[0],      '0);
    chk("rst_addr",   WW'(addr[0]), '0);
    chk("rst_data_b", data[1],      '0);
    chk("rst_ready_c", WW'(rdy[2]), '0);
    rst_n = 1'b1;

    // Single cluster, back-to-back elements 1..9.
    s_w = wr_n[0];
    s_f = fin_n[0];
    start_pass(0, 20'h10);
    chk("t1_busy",  WW'(busy[0]), WW'(1));
    chk("t1_ready", WW'(rdy[0]),  WW'(1));
    send(0, 9, 1, 1'b0);
    chk("t1_we_next_cycle", WW'(we[0]),  WW'(1));
    chk("t1_ready_bubble",  WW'(rdy[0]), '0);
    chk("t1_addr",          WW'(addr[0]), WW'(20'h10));
    chk("t1_word",          data[0],     pack(1, 9));
    wait_idle(0);
    chk("t1_write_count",  WW'(wr_n[0] - s_w), WW'(1));
    chk("t1_write_cycle",  WW'(wr_cyc[0][s_w]), WW'(last_acc));
    chk("t1_finish_count", WW'(fin_n[0] - s_f), WW'(1));
    chk("t1_finish_cycle", WW'(fin_cyc[0]), WW'(last_acc + 1));
    chk("t1_word_held",    data[0], pack(1, 9));

    // Three clusters with random valid gaps.
    s_w = wr_n[1];
    s_f = fin_n[1];
    start_pass(1, 20'h0);
    send(1, 27, 100, 1'b1);
    wait_idle(1);
    chk("t2_write_count", WW'(wr_n[1] - s_w), WW'(3));
    for (int c = 0; c < 3; c++) begin
      chk("t2_addr", WW'(wr_addr[1][s_w + c]), WW'(c));
      chk("t2_word", wr_data[1][s_w + c], pack(100 + 9 * c, 9));
    end
    chk("t2_ready_in_write", WW'(rdy_wr[1]), '0);
    chk("t2_finish_count",   WW'(fin_n[1] - s_f), WW'(1));

    // Address wrap at the top of the address space.
    s_w = wr_n[2];
    start_pass(2, 20'hFFFFF);
    send(2, 18, 1000, 1'b0);
    wait_idle(2);
    chk("t3_write_count", WW'(wr_n[2] - s_w), WW'(2));
    chk("t3_addr0", WW'(wr_addr[2][s_w]),     WW'(20'hFFFFF));
    chk("t3_addr1", WW'(wr_addr[2][s_w + 1]), '0);
    chk("t3_word1", wr_data[2][s_w + 1], pack(1009, 9));

    // Reset in the middle of a word.
    s_w = wr_n[0];
    start_pass(0, 20'h55);
    send(0, 5, 7, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_we",    WW'(we[0]),   '0);
    chk("t4_rst_ready", WW'(rdy[0]),  '0);
    chk("t4_rst_busy",  WW'(busy[0]), '0);
    chk("t4_rst_data",  data[0],      '0);
    chk("t4_rst_addr",  WW'(addr[0]), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t4_no_write", WW'(wr_n[0] - s_w), '0);
    start_pass(0, 20'h56);
    send(0, 9, 200, 1'b0);
    wait_idle(0);
    chk("t4_write_count", WW'(wr_n[0] - s_w), WW'(1));
    chk("t4_addr", WW'(wr_addr[0][s_w]), WW'(20'h56));
    chk("t4_word", wr_data[0][s_w], pack(200, 9));

    // start pulses during FILL and WRITE must be ignored.
    s_w = wr_n[0];
    s_f = fin_n[0];
    start_pass(0, 20'h40);
    send(0, 4, 300, 1'b0);
    @(negedge clk);
    base_address = 20'h99;
    start[0]     = 1'b1;
    @(negedge clk);
    start[0]     = 1'b0;
    send(0, 5, 304, 1'b0);
    base_address = 20'h77;
    start[0]     = 1'b1;
    @(posedge clk);
    #1;
    start[0]     = 1'b0;
    wait_idle(0);
    chk("t5_write_count",  WW'(wr_n[0] - s_w), WW'(1));
    chk("t5_addr",         WW'(wr_addr[0][s_w]), WW'(20'h40));
    chk("t5_word",         wr_data[0][s_w], pack(300, 9));
    chk("t5_finish_count", WW'(fin_n[0] - s_f), WW'(1));
    repeat (3) @(negedge clk);
    chk("t5_stays_idle",   WW'(busy[0]), '0);

`ifdef MEMP_WB_FLUSH_EN
    // Flush after 4 lanes of the second word: stale lanes from word 0 must be zeroed.
    s_w = wr_n[1];
    s_f = fin_n[1];
    start_pass(1, 20'h30);
    send(1, 13, 500, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(1);
    chk("t6_write_count",  WW'(wr_n[1] - s_w), WW'(2));
    chk("t6_addr",         WW'(wr_addr[1][s_w + 1]), WW'(20'h31));
    chk("t6_word",         wr_data[1][s_w + 1], pack(509, 4));
    chk("t6_finish_count", WW'(fin_n[1] - s_f), WW'(1));

    // Flush on an empty word ends the pass without a write.
    s_w = wr_n[1];
    s_f = fin_n[1];
    start_pass(1, 20'h40);
    send(1, 9, 600, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(1);
    chk("t6_empty_write_count",  WW'(wr_n[1] - s_w), WW'(1));
    chk("t6_empty_finish_count", WW'(fin_n[1] - s_f), WW'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
